// File: rtl/pipe_seq_ctrl.sv
// Sequencing controller for the three-stage pipelined datapath: start/busy/done
// handshake, round-robin multiplier lanes, fill tracking and a fixed-length drain.
module pipe_seq_ctrl #(
    parameter int IDX_W       = 9,
    parameter int NUM_MUL     = 3,
    parameter int FILL_DEPTH  = 9,
    parameter int DRAIN_DEPTH = 6,
    parameter int CNT_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stall,
    input  logic [IDX_W-1:0]           a_new,
    input  logic [IDX_W-1:0]           a_old,
    input  logic [IDX_W-1:0]           b_new,
    output logic                       clear_pipes,
    output logic [1:0]                 p1_en,
    output logic [2*NUM_MUL-1:0]       p2_en,
    output logic [1:0]                 p3_en,
    output logic [3:0]                 s1_mux,
    output logic [$clog2(NUM_MUL)-1:0] mul_idx,
    output logic                       out_en,
    output logic                       first,
    output logic                       busy,
    output logic                       done
);
    localparam int MW = $clog2(NUM_MUL);
    localparam logic [2*NUM_MUL-1:0] LANE0 = {2'b11, {(2*NUM_MUL-2){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLEAR, INIT, PH1, PH2, PH3, DRAIN, DONE} state_t;

    state_t            state;
    logic [MW-1:0]     mul_q;
    logic [CNT_W-1:0]  fill_cnt;
    logic [CNT_W-1:0]  drain_cnt;
    logic [3:0]        mux_last;
    logic [IDX_W-1:0]  b_m1;
    logic              running;
    logic              hold;
    logic              show;

    assign b_m1    = b_new - IDX_W'(1);
    assign running = (state == PH1) || (state == PH2) || (state == PH3) || (state == DRAIN);
    assign hold    = stall && running;
    // Lane index and fill flag are hidden until the run has been cleared.
    assign show    = (state != IDLE) && (state != CLEAR);
    assign mul_idx = show ? mul_q : '0;
    assign first   = show && (fill_cnt == CNT_W'(FILL_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mul_q     <= '0;
            fill_cnt  <= '0;
            drain_cnt <= '0;
            mux_last  <= '0;
        end else begin
            case (state)
                IDLE:  if (start) state <= CLEAR;
                CLEAR: begin
                    fill_cnt  <= '0;
                    drain_cnt <= '0;
                    mul_q     <= '0;
                    state     <= INIT;
                end
                INIT:  state <= PH1;
                PH1, PH2, PH3: if (!stall) begin
                    mux_last <= s1_mux;
                    if (fill_cnt != CNT_W'(FILL_DEPTH)) fill_cnt <= fill_cnt + CNT_W'(1);
                    if (state != PH3)
                        mul_q <= (mul_q == MW'(NUM_MUL-1)) ? '0 : mul_q + MW'(1);
                    case (state)
                        PH1:     state <= (b_m1 == a_new) ? DRAIN : PH2;
                        PH2:     state <= PH3;
                        default: state <= (a_old == b_m1) ? DRAIN : PH1;
                    endcase
                end
                DRAIN: if (!stall) begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                    if (drain_cnt == CNT_W'(DRAIN_DEPTH-1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        clear_pipes = 1'b0;
        p1_en       = '0;
        p2_en       = '0;
        p3_en       = '0;
        s1_mux      = '0;
        out_en      = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            CLEAR: clear_pipes = 1'b1;
            INIT: begin
                p1_en  = 2'b01;
                s1_mux = 4'b0001;
            end
            PH1, PH2: begin
                s1_mux = (state == PH1) ? 4'b0111 : 4'b1011;
                p2_en  = LANE0 >> {mul_q, 1'b0};
                p3_en  = 2'b11;
                out_en = 1'b1;
            end
            PH3: begin
                p1_en  = 2'b11;
                s1_mux = 4'b1100;
                p3_en  = 2'b11;
                out_en = 1'b1;
            end
            DRAIN: begin
                s1_mux = mux_last;
                p3_en  = 2'b11;
                out_en = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        // Back-pressure kills every enable but leaves the mux selects alone.
        if (hold) begin
            p1_en  = '0;
            p2_en  = '0;
            p3_en  = '0;
            out_en = 1'b0;
        end
    end
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: two builds (3 lanes/drain 6, 4 lanes/drain 3) checked
// cycle by cycle against a run-position model (phase count, drain count).
module tb_pipe_seq_ctrl;
    localparam int W  = 9;
    localparam int FD = 9;
    localparam int K_IDLE = 0, K_CLR = 1, K_INI = 2, K_PH = 3, K_DR = 4, K_DN = 5;

    logic clk = 1'b0, rst_n = 1'b0, start3 = 1'b0, start4 = 1'b0, stall = 1'b0;
    logic [W-1:0] a_new = '0, a_old = '0, b_new = '0;
    always #5 clk = ~clk;

    logic cp3, oe3, f3, bz3, dn3, cp4, oe4, f4, bz4, dn4;
    logic [1:0] p1_3, p3_3, mi3, p1_4, p3_4, mi4;
    logic [5:0] p2_3;
    logic [7:0] p2_4;
    logic [3:0] s1_3, s1_4;

    pipe_seq_ctrl #(.IDX_W(W), .NUM_MUL(3), .FILL_DEPTH(FD), .DRAIN_DEPTH(6), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stall(stall), .a_new(a_new), .a_old(a_old),
        .b_new(b_new), .clear_pipes(cp3), .p1_en(p1_3), .p2_en(p2_3), .p3_en(p3_3), .s1_mux(s1_3),
        .mul_idx(mi3), .out_en(oe3), .first(f3), .busy(bz3), .done(dn3));

    pipe_seq_ctrl #(.IDX_W(W), .NUM_MUL(4), .FILL_DEPTH(FD), .DRAIN_DEPTH(3), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stall(stall), .a_new(a_new), .a_old(a_old),
        .b_new(b_new), .clear_pipes(cp4), .p1_en(p1_4), .p2_en(p2_4), .p3_en(p3_4), .s1_mux(s1_4),
        .mul_idx(mi4), .out_en(oe4), .first(f4), .busy(bz4), .done(dn4));

    int checks = 0, errors = 0;
    int cur = 0;
    int m_kind = K_IDLE, m_j = 0, m_d = 0;
    logic [3:0] m_mux = '0;
    int dact = 0, dcnt = 0;
    string tname = "reset";

    function automatic int nm_cur();
        return (cur == 0) ? 3 : 4;
    endfunction

    function automatic int dd_cur();
        return (cur == 0) ? 6 : 3;
    endfunction

    function automatic logic [3:0] muxv(input int ph);
        return (ph == 0) ? 4'b0111 : (ph == 1) ? 4'b1011 : 4'b1100;
    endfunction

    // {clear, p1[2], p2[16], p3[2], s1[4], mul_idx[4], out_en, first, busy, done}
    function automatic logic [32:0] obs();
        if (cur == 0) return {cp3, p1_3, 10'b0, p2_3, p3_3, s1_3, 2'b0, mi3, oe3, f3, bz3, dn3};
        return {cp4, p1_4, 8'b0, p2_4, p3_4, s1_4, 2'b0, mi4, oe4, f4, bz4, dn4};
    endfunction

    function automatic logic [32:0] expv(input logic stl);
        logic cp, oe, f, bz, dn;
        logic [1:0] p1, p3;
        logic [15:0] p2;
        logic [3:0] s1, mi;
        int nmv, lane;
        cp = 0; oe = 0; f = 0; bz = 0; dn = 0; p1 = 0; p3 = 0; p2 = 0; s1 = 0; mi = 0;
        nmv  = nm_cur();
        lane = (2 * (m_j / 3) + m_j % 3) % nmv;
        if (m_kind >= K_PH) begin
            bz = 1; mi = 4'(lane); f = (m_j >= FD);
        end
        case (m_kind)
            K_CLR: begin cp = 1; bz = 1; end
            K_INI: begin p1 = 2'b01; s1 = 4'b0001; bz = 1; end
            K_PH: begin
                s1 = muxv(m_j % 3); p3 = 2'b11; oe = 1;
                if (m_j % 3 == 2) p1 = 2'b11;
                else p2 = 16'h3 << (2 * (nmv - 1 - lane));
            end
            K_DR: begin s1 = m_mux; p3 = 2'b11; oe = 1; end
            K_DN: dn = 1;
            default: ;
        endcase
        if (stl && (m_kind == K_PH || m_kind == K_DR)) begin
            p1 = 0; p2 = 0; p3 = 0; oe = 0;
        end
        return {cp, p1, p2, p3, s1, mi, oe, f, bz, dn};
    endfunction

    // Advance the run position from the inputs present at this rising edge.
    task automatic model_update(input logic stl, input logic st);
        int bm1, ph;
        logic endc;
        bm1 = (int'(b_new) + 511) % 512;
        case (m_kind)
            K_IDLE: if (st) m_kind = K_CLR;
            K_CLR:  begin m_kind = K_INI; m_j = 0; m_d = 0; end
            K_INI:  m_kind = K_PH;
            K_PH: if (!stl) begin
                ph    = m_j % 3;
                endc  = (ph == 0 && bm1 == int'(a_new)) || (ph == 2 && bm1 == int'(a_old));
                m_mux = muxv(ph);
                m_j++;
                if (endc) begin m_kind = K_DR; m_d = 0; end
            end
            K_DR: if (!stl) begin
                m_d++;
                if (m_d == dd_cur()) m_kind = K_DN;
            end
            K_DN: m_kind = K_IDLE;
            default: m_kind = K_IDLE;
        endcase
    endtask

    // Called at a falling edge: drive, check, take the rising edge, return at next falling edge.
    task automatic step(input logic stl, input logic st);
        logic [32:0] o, e;
        stall = stl;
        if (cur == 0) start3 = st; else start4 = st;
        #1;
        o = obs();
        e = expv(stl);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (pos kind %0d j %0d d %0d)", tname, o, e, m_kind, m_j, m_d);
        end
        if (o[3] && o[31:30] == 2'b00 && o[29:14] == 16'h0) dact++;
        if (o[0]) dcnt++;
        @(posedge clk);
        model_update(stl, st);
        @(negedge clk);
    endtask

    task automatic pick_normal(input bit rnd);
        int a, b, o;
        if (!rnd) begin
            a_new = 9'd3; b_new = 9'd20; a_old = 9'd3;
            return;
        end
        do begin
            a = $urandom_range(511); b = $urandom_range(511); o = $urandom_range(511);
        end while ((b + 511) % 512 == a || (b + 511) % 512 == o);
        a_new = W'(a); b_new = W'(b); a_old = W'(o);
    endtask

    // One full run from start to IDLE. etype 1 ends in PH1, 2 ends in PH3, at group egrp.
    task automatic run(input int etype, input int egrp, input int pct, input bit dstall,
                       input bit rnd, input bit noise, input int ea, input int eb, input int eo);
        int n, ds, r;
        logic stl, st;
        n = 0; ds = 0; dact = 0; dcnt = 0;
        pick_normal(rnd);
        step(1'b0, 1'b1);
        while (m_kind != K_IDLE && n < 400) begin
            pick_normal(rnd);
            if (m_kind == K_PH && m_j / 3 == egrp && m_j % 3 == ((etype == 1) ? 0 : 2)) begin
                if (ea >= 0) begin
                    a_new = W'(ea); b_new = W'(eb); a_old = W'(eo);
                end else if (etype == 1) begin
                    r = $urandom_range(511); a_new = W'(r); b_new = W'((r + 1) % 512);
                end else begin
                    r = $urandom_range(511); b_new = W'(r); a_old = W'((r + 511) % 512);
                end
            end
            if (dstall) stl = (m_kind == K_DR && m_d == 2 && ds < 4);
            else        stl = ($urandom_range(99) < pct);
            if (dstall && stl) ds++;
            st = noise && ($urandom_range(3) == 0);
            step(stl, st);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout: run still active after %0d cycles, required back in idle", tname, n);
        end
        checks++;
        if (dact !== dd_cur()) begin
            errors++;
            $display("FAIL %s_drain_len: got %0d active drain cycles, required %0d", tname, dact, dd_cur());
        end
        checks++;
        if (dcnt !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, required 1", tname, dcnt);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tname = "reset";
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cur = d;
            step(1'b0, 1'b0);
        end
        rst_n = 1'b1;
        cur = 0;
    endtask

    task automatic test_fill_lanes();
        tname = "fill_lanes";
        cur = 0;
        run(1, 5, 0, 1'b0, 1'b0, 1'b0, 7, 8, 3);
    endtask

    task automatic test_end_conditions();
        tname = "end_ph1";
        run(1, 3, 0, 1'b0, 1'b1, 1'b0, 7, 8, 100);
        tname = "end_ph3";
        run(2, 1, 0, 1'b0, 1'b1, 1'b0, 200, 1, 0);
        tname = "wrap_ph1";
        run(1, 0, 0, 1'b0, 1'b1, 1'b0, 511, 0, 77);
    endtask

    task automatic test_drain_stall();
        tname = "drain_stall";
        run(1, 2, 0, 1'b1, 1'b1, 1'b0, -1, 0, 0);
    endtask

    task automatic test_random_stall();
        tname = "random_stall";
        for (int i = 0; i < 6; i++)
            run(1 + (i % 2), int'($urandom_range(4)), 30, 1'b0, 1'b1, 1'b1, -1, 0, 0);
    endtask

    task automatic test_num_mul4();
        tname = "num_mul4";
        cur = 1;
        run(1, 4, 0, 1'b0, 1'b1, 1'b1, -1, 0, 0);
        run(2, 3, 25, 1'b0, 1'b1, 1'b1, -1, 0, 0);
        cur = 0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        tname = "reset_mid_run";
        cur = 0; n = 0;
        a_new = 9'd5; b_new = 9'd9; a_old = 9'd5;
        step(1'b0, 1'b1);
        while (!(m_kind == K_PH && m_j == 4) && n < 50) begin
            step(1'b0, 1'b0);
            n++;
        end
        rst_n = 1'b0;
        m_kind = K_IDLE;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        tname = "after_reset";
        run(2, 2, 0, 1'b0, 1'b1, 1'b0, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        tname = "back_to_back";
        for (int i = 0; i < 3; i++) run(1, i, 10, 1'b0, 1'b1, 1'b0, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill_lanes();
        test_end_conditions();
        test_drain_stall();
        test_random_stall();
        test_num_mul4();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
